// File: rtl/des_decrypt_core.sv
// Single-block DES decryption core, one Feistel round per clock.
// C/D rotate right each round, so the subkeys come out on the fly in the order K16..K1.
module des_decrypt_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy
);
    // state | meaning
    // IDLE  | waiting for a ciphertext/key pair, in_ready high
    // ROUND | one Feistel round per clock, cnt_q = round number - 1
    // DONE  | plaintext held on data_out until out_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
    // Row-major: entry index = row * 16 + column.
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [63:0] dout_q, dout_d;
    logic        ovalid_q, ovalid_d;

    logic [63:0] ip_data, pre_out, fp_data;
    logic [55:0] pc1_key, cd_rot;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey, e_r, s_in;
    logic [31:0] s_out, f_out;
    logic        parity_unused;

    // Parity bits never reach PC-1; folding them here keeps lint quiet about them.
    assign parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    for (genvar g = 0; g < 64; g++) begin : g_ip_fp
        assign ip_data[63-g] = data_in[64-IP_T[g]];
        assign fp_data[63-g] = pre_out[64-FP_T[g]];
    end

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign pc1_key[55-g] = key_in[64-PC1_T[g]];
    end

    for (genvar g = 0; g < 48; g++) begin : g_pc2_e
        assign subkey[47-g] = cd_rot[56-PC2_T[g]];
        assign e_r[47-g]    = r_q[32-E_T[g]];
    end

    assign s_in = e_r ^ subkey;

    // Box input b1..b6: row = {b1,b6}, column = b2..b5.
    for (genvar g = 0; g < 8; g++) begin : g_sbox
        localparam int HI = 47 - 6 * g;
        assign s_out[31-4*g -: 4] = 4'(SBOX[g][{s_in[HI], s_in[HI-5], s_in[HI-1 -: 4]}]);
    end

    for (genvar g = 0; g < 32; g++) begin : g_p
        assign f_out[31-g] = s_out[32-P_T[g]];
    end

    always_comb begin
        case (cnt_q)
            4'd0: begin
                c_rot = c_q;
                d_rot = d_q;
            end
            4'd1, 4'd8, 4'd15: begin
                c_rot = {c_q[0], c_q[27:1]};
                d_rot = {d_q[0], d_q[27:1]};
            end
            default: begin
                c_rot = {c_q[1:0], c_q[27:2]};
                d_rot = {d_q[1:0], d_q[27:2]};
            end
        endcase
    end

    assign cd_rot  = {c_rot, d_rot};
    // Final round leaves the halves swapped ahead of FP.
    assign pre_out = {l_q ^ f_out, r_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        l_d      = l_q;
        r_d      = r_q;
        c_d      = c_q;
        d_d      = d_q;
        dout_d   = dout_q;
        ovalid_d = ovalid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    l_d     = ip_data[63:32];
                    r_d     = ip_data[31:0];
                    c_d     = pc1_key[55:28];
                    d_d     = pc1_key[27:0];
                    cnt_d   = 4'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                c_d   = c_rot;
                d_d   = d_rot;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    dout_d   = fp_data;
                    ovalid_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            l_q      <= l_d;
            r_q      <= r_d;
            c_q      <= c_d;
            d_q      <= d_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_ROUND) || (state_q == S_DONE);
    assign out_valid = ovalid_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known DES vectors, handshake timing, hold, reset abort.
module tb_des_decrypt_core;
    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT_A   = 64'h85E813540F0AB405;
    localparam logic [63:0] PT_A   = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] CT_B   = 64'h0000000000000000;
    localparam logic [63:0] PT_B   = 64'h8787878787878787;
    localparam logic [63:0] KEY_AP = 64'h123556789ABDDEF0;   // KEY_A with every byte LSB flipped
    localparam logic [63:0] K16_A  = 64'h00001B02EFFC7072;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] data_in, key_in, data_out;
    logic [63:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          lat;

    always #5 clk = ~clk;

    des_decrypt_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_pop(input string tag);
        chk({tag, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk(tag, data_out, exp_q.pop_front());
    endtask

    task automatic accept(input logic [63:0] key, input logic [63:0] ct,
                          input logic [63:0] pt, input string tag);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        key_in   = key;
        data_in  = ct;
        tick();
        exp_q.push_back(pt);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov0"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data_in = '0; key_in = '0;
        #12;
        chk("rst_rdy", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_dout", data_out, 64'd0);
        rst_n = 1'b1;
        tick();

        // out_ready with nothing pending is ignored
        out_ready = 1'b1;
        tick(); tick();
        chk("orq_ov", 64'(out_valid), 64'd0);
        chk("orq_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // Vector A: latency and round-16 subkey
        accept(KEY_A, CT_A, PT_A, "a");
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("a_k16", 64'(dut.subkey), K16_A);
        chk("a_early", 64'(out_valid), 64'd0);
        wait_out(lat);
        chk("a_lat", 64'(lat + 15), 64'd16);
        check_pop("a_data");
        drain("a");
        chk("a_hold", data_out, PT_A);

        // Vector B
        accept(KEY_B, CT_B, PT_B, "b");
        in_valid = 1'b0;
        wait_out(lat);
        chk("b_lat", 64'(lat), 64'd16);
        check_pop("b_data");
        drain("b");

        // Vector A with input noise during ROUND/DONE and a delayed consumer
        accept(KEY_A, CT_A, PT_A, "c");
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            in_valid = 1'($urandom_range(1));
            data_in  = {$urandom(), $urandom()};
            key_in   = {$urandom(), $urandom()};
            chk("c_rdy_round", 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
        chk("c_lat", 64'(lat), 64'd16);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(1));
            data_in  = {$urandom(), $urandom()};
            key_in   = {$urandom(), $urandom()};
            tick();
            chk("c_hold_ov", 64'(out_valid), 64'd1);
            chk("c_hold_data", data_out, PT_A);
            chk("c_hold_rdy", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check_pop("c_data");
        drain("c");
        chk("c_after", data_out, PT_A);
        tick();
        chk("c_one_hs", 64'(out_valid), 64'd0);

        // Back-to-back A then B, in_valid and out_ready held high
        out_ready = 1'b1;
        accept(KEY_A, CT_A, PT_A, "d1");
        data_in = CT_B;
        key_in  = KEY_B;
        wait_out(lat);
        chk("d1_lat", 64'(lat), 64'd16);
        check_pop("d1_data");
        tick();
        chk("d_gap_ov", 64'(out_valid), 64'd0);
        chk("d_gap_rdy", 64'(in_ready), 64'd1);
        tick();
        exp_q.push_back(PT_B);
        chk("d2_busy", 64'(busy), 64'd1);
        chk("d2_rdy", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_out(lat);
        chk("d2_lat", 64'(lat), 64'd16);
        check_pop("d2_data");
        drain("d2");

        // Reset in the middle of a run
        accept(KEY_A, CT_A, PT_A, "e");
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("e_rst_ov", 64'(out_valid), 64'd0);
        chk("e_rst_dout", data_out, 64'd0);
        chk("e_rst_rdy", 64'(in_ready), 64'd1);
        chk("e_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("e_no_out", 64'(out_valid), 64'd0);
        accept(KEY_B, CT_B, PT_B, "e2");
        in_valid = 1'b0;
        wait_out(lat);
        chk("e2_lat", 64'(lat), 64'd16);
        check_pop("e2_data");
        drain("e2");

        // Parity bits flipped: same plaintext
        accept(KEY_AP, CT_A, PT_A, "f");
        in_valid = 1'b0;
        wait_out(lat);
        chk("f_lat", 64'(lat), 64'd16);
        check_pop("f_data");
        drain("f");

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
